// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller FSM encoding, the hard-wired zero register index,
// the default MDU timeout and the RAW match rule used by every comparator.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MDU_LAUNCH = 2'd1,
        MDU_WAIT   = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         MDU_TIMEOUT_DEFAULT = 64;

    // A source conflicts with a writer only when both sides really use x1..x31.
    function automatic logic raw_match(input logic [4:0] rs,
                                       input logic       rs_used,
                                       input logic [4:0] rd,
                                       input logic       rd_en);
        return rs_used && (rs != REG_ZERO) && rd_en && (rd != REG_ZERO) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Purely combinational RAW comparator for one source/writer pair.
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_use,
    input  logic [4:0] i_rd,
    input  logic       i_reg_en,
    output logic       o_match
);

    assign o_match = raw_match(i_rs, i_use, i_rd, i_reg_en);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock and scheduling controller for the 5-stage RV32IM pipeline.
// Stalls ID on RAW hazards (no forwarding), squashes wrong-path fetches on
// taken branches, and freezes the pipeline around the multi-cycle MDU.
// Optional build macro HAZARD_PERF_EN adds three 32-bit performance counters
// (PERF_STALL, PERF_FLUSH, PERF_MDU).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT    = MDU_TIMEOUT_DEFAULT,
    parameter int WB_WRITE_FIRST = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USE_RS1,
    input  logic        ID_USE_RS2,
    input  logic [4:0]  EX_RD,
    input  logic [4:0]  MA_RD,
    input  logic [4:0]  WB_RD,
    input  logic        EX_REG_EN,
    input  logic        MA_REG_EN,
    input  logic        WB_REG_EN,
    input  logic        EX_MDU,
    input  logic        BR_TAKEN,
    input  logic        MDU_DONE,
    output logic        PC_STALL,
    output logic        IFID_STALL,
    output logic        IFID_FLUSH,
    output logic        IDEX_STALL,
    output logic        IDEX_BUBBLE,
    output logic        EXMA_BUBBLE,
    output logic        MDU_START,
`ifdef HAZARD_PERF_EN
    output logic [31:0] PERF_STALL,
    output logic [31:0] PERF_FLUSH,
    output logic [31:0] PERF_MDU,
`endif
    output logic        MDU_ERR
);

    localparam logic [7:0] TIMEOUT_C = 8'(MDU_TIMEOUT);

    hz_state_t  r_state;
    hz_state_t  w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_err;
    logic       r_block;

    logic w_rs1_ex, w_rs2_ex, w_rs1_ma, w_rs2_ma, w_rs1_wb, w_rs2_wb;
    logic w_hz;
    logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
    logic w_idex_bubble, w_exma_bubble, w_mdu_start;
    logic w_leave_mdu, w_err_set;

    hazard_cmp u_cmp_rs1_ex (.i_rs(ID_RS1), .i_use(ID_USE_RS1), .i_rd(EX_RD), .i_reg_en(EX_REG_EN), .o_match(w_rs1_ex));
    hazard_cmp u_cmp_rs2_ex (.i_rs(ID_RS2), .i_use(ID_USE_RS2), .i_rd(EX_RD), .i_reg_en(EX_REG_EN), .o_match(w_rs2_ex));
    hazard_cmp u_cmp_rs1_ma (.i_rs(ID_RS1), .i_use(ID_USE_RS1), .i_rd(MA_RD), .i_reg_en(MA_REG_EN), .o_match(w_rs1_ma));
    hazard_cmp u_cmp_rs2_ma (.i_rs(ID_RS2), .i_use(ID_USE_RS2), .i_rd(MA_RD), .i_reg_en(MA_REG_EN), .o_match(w_rs2_ma));

    // The WB stage only matters when the register file cannot write ahead of the ID read.
    generate
        if (WB_WRITE_FIRST == 0) begin : g_wb_cmp
            hazard_cmp u_cmp_rs1_wb (.i_rs(ID_RS1), .i_use(ID_USE_RS1), .i_rd(WB_RD), .i_reg_en(WB_REG_EN), .o_match(w_rs1_wb));
            hazard_cmp u_cmp_rs2_wb (.i_rs(ID_RS2), .i_use(ID_USE_RS2), .i_rd(WB_RD), .i_reg_en(WB_REG_EN), .o_match(w_rs2_wb));
        end else begin : g_wb_none
            logic [5:0] w_wb_unused;
            assign w_wb_unused = {WB_RD, WB_REG_EN};
            assign w_rs1_wb    = 1'b0;
            assign w_rs2_wb    = 1'b0;
        end
    endgenerate

    assign w_hz = w_rs1_ex | w_rs2_ex | w_rs1_ma | w_rs2_ma | w_rs1_wb | w_rs2_wb;

    // Next-state and pipeline control decode; branch beats MDU beats RAW stall.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exma_bubble = 1'b0;
        w_mdu_start   = 1'b0;
        w_leave_mdu   = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            RUN: begin
                if (BR_TAKEN) begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else if (EX_MDU && !r_block) begin
                    w_mdu_start   = 1'b1;
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exma_bubble = 1'b1;
                    w_state_next  = MDU_LAUNCH;
                end else if (w_hz) begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_bubble = 1'b1;
                end else begin
                    w_state_next  = RUN;
                end
            end
            MDU_LAUNCH: begin
                w_cnt_next = 8'd1;
                if (MDU_DONE) begin
                    w_leave_mdu  = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exma_bubble = 1'b1;
                    w_state_next  = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (MDU_DONE) begin
                    w_leave_mdu  = 1'b1;
                    w_state_next = RUN;
                end else if (r_cnt >= TIMEOUT_C) begin
                    w_leave_mdu  = 1'b1;
                    w_err_set    = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_pc_stall    = 1'b1;
                    w_ifid_stall  = 1'b1;
                    w_idex_stall  = 1'b1;
                    w_exma_bubble = 1'b1;
                    w_cnt_next    = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Controller state, MDU busy counter, sticky timeout flag and relaunch guard.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
            r_block <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= r_err | w_err_set;
            r_block <= w_leave_mdu;
        end
    end

    assign PC_STALL    = ~RESET & w_pc_stall;
    assign IFID_STALL  = ~RESET & w_ifid_stall;
    assign IFID_FLUSH  = ~RESET & w_ifid_flush;
    assign IDEX_STALL  = ~RESET & w_idex_stall;
    assign IDEX_BUBBLE = ~RESET & w_idex_bubble;
    assign EXMA_BUBBLE = ~RESET & w_exma_bubble;
    assign MDU_START   = ~RESET & w_mdu_start;
    assign MDU_ERR     = ~RESET & r_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_mdu;

    // Free-running wrap-around event counters for stall, flush and MDU occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 32'd0;
            r_perf_mdu   <= 32'd0;
        end else begin
            r_perf_stall <= r_perf_stall + {31'd0, w_pc_stall};
            r_perf_flush <= r_perf_flush + {31'd0, w_ifid_flush};
            r_perf_mdu   <= r_perf_mdu + {31'd0, (r_state != RUN)};
        end
    end

    assign PERF_STALL = r_perf_stall;
    assign PERF_FLUSH = r_perf_flush;
    assign PERF_MDU   = r_perf_mdu;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: reset, a vector table of RUN
// decisions, directed multi-cycle sequences and a randomized run against a
// behavioural model. Three instances: default, WB compared, short timeout.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] exrd;
        logic [4:0] mard;
        logic [4:0] wbrd;
        logic       exen;
        logic       maen;
        logic       wben;
        logic       exmdu;
        logic       br;
        logic       done;
    } vec_t;

    typedef struct packed {
        vec_t       v;
        logic [7:0] e_wf1;
        logic [7:0] e_wf0;
    } rec_t;

    // age = 0 when the MDU is idle, else cycles since the start pulse
    typedef struct packed {
        int   age;
        logic err;
        logic just_ret;
    } mst_t;

    // output bit order: pc, ifid_stall, ifid_flush, idex_stall, idex_bubble, exma_bubble, start, err
    localparam logic [7:0] O_NONE   = 8'h00;
    localparam logic [7:0] O_RAW    = 8'hC8;
    localparam logic [7:0] O_BRANCH = 8'h28;
    localparam logic [7:0] O_START  = 8'hD6;
    localparam logic [7:0] O_FREEZE = 8'hD4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0, ma_rd = 5'd0, wb_rd = 5'd0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       ex_reg_en = 1'b0, ma_reg_en = 1'b0, wb_reg_en = 1'b0;
    logic       ex_mdu = 1'b0, br_taken = 1'b0, mdu_done = 1'b0;

    wire [7:0] ov0, ov1, ov2;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_s0, perf_f0, perf_m0, perf_s1, perf_f1, perf_m1, perf_s2, perf_f2, perf_m2;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_TIMEOUT(64), .WB_WRITE_FIRST(1)) dut (
        .CLK(clk), .RESET(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USE_RS1(id_use_rs1), .ID_USE_RS2(id_use_rs2),
        .EX_RD(ex_rd), .MA_RD(ma_rd), .WB_RD(wb_rd),
        .EX_REG_EN(ex_reg_en), .MA_REG_EN(ma_reg_en), .WB_REG_EN(wb_reg_en),
        .EX_MDU(ex_mdu), .BR_TAKEN(br_taken), .MDU_DONE(mdu_done),
        .PC_STALL(ov0[7]), .IFID_STALL(ov0[6]), .IFID_FLUSH(ov0[5]), .IDEX_STALL(ov0[4]),
        .IDEX_BUBBLE(ov0[3]), .EXMA_BUBBLE(ov0[2]), .MDU_START(ov0[1]),
`ifdef HAZARD_PERF_EN
        .PERF_STALL(perf_s0), .PERF_FLUSH(perf_f0), .PERF_MDU(perf_m0),
`endif
        .MDU_ERR(ov0[0])
    );

    pipeline_hazard_ctrl #(.MDU_TIMEOUT(64), .WB_WRITE_FIRST(0)) dut_wb0 (
        .CLK(clk), .RESET(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USE_RS1(id_use_rs1), .ID_USE_RS2(id_use_rs2),
        .EX_RD(ex_rd), .MA_RD(ma_rd), .WB_RD(wb_rd),
        .EX_REG_EN(ex_reg_en), .MA_REG_EN(ma_reg_en), .WB_REG_EN(wb_reg_en),
        .EX_MDU(ex_mdu), .BR_TAKEN(br_taken), .MDU_DONE(mdu_done),
        .PC_STALL(ov1[7]), .IFID_STALL(ov1[6]), .IFID_FLUSH(ov1[5]), .IDEX_STALL(ov1[4]),
        .IDEX_BUBBLE(ov1[3]), .EXMA_BUBBLE(ov1[2]), .MDU_START(ov1[1]),
`ifdef HAZARD_PERF_EN
        .PERF_STALL(perf_s1), .PERF_FLUSH(perf_f1), .PERF_MDU(perf_m1),
`endif
        .MDU_ERR(ov1[0])
    );

    pipeline_hazard_ctrl #(.MDU_TIMEOUT(4), .WB_WRITE_FIRST(1)) dut_t4 (
        .CLK(clk), .RESET(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USE_RS1(id_use_rs1), .ID_USE_RS2(id_use_rs2),
        .EX_RD(ex_rd), .MA_RD(ma_rd), .WB_RD(wb_rd),
        .EX_REG_EN(ex_reg_en), .MA_REG_EN(ma_reg_en), .WB_REG_EN(wb_reg_en),
        .EX_MDU(ex_mdu), .BR_TAKEN(br_taken), .MDU_DONE(mdu_done),
        .PC_STALL(ov2[7]), .IFID_STALL(ov2[6]), .IFID_FLUSH(ov2[5]), .IDEX_STALL(ov2[4]),
        .IDEX_BUBBLE(ov2[3]), .EXMA_BUBBLE(ov2[2]), .MDU_START(ov2[1]),
`ifdef HAZARD_PERF_EN
        .PERF_STALL(perf_s2), .PERF_FLUSH(perf_f2), .PERF_MDU(perf_m2),
`endif
        .MDU_ERR(ov2[0])
    );

    function automatic vec_t mkv(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] exrd, input logic exen, input logic [4:0] mard, input logic maen,
                                 input logic [4:0] wbrd, input logic wben, input logic br);
        vec_t v;
        v = '0;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.exrd = exrd; v.exen = exen; v.mard = mard; v.maen = maen;
        v.wbrd = wbrd; v.wben = wben; v.br = br;
        return v;
    endfunction

    // Does any live, non-x0 writer target a register that ID actually reads?
    function automatic logic model_hz(input vec_t v, input bit wb_first);
        logic [4:0] rd [3];
        logic       en [3];
        logic       h;
        h = 1'b0;
        rd[0] = v.exrd; rd[1] = v.mard; rd[2] = v.wbrd;
        en[0] = v.exen; en[1] = v.maen; en[2] = v.wben;
        for (int w = 0; w < 3; w++) begin
            if (en[w] && rd[w] != 5'd0 && !(w == 2 && wb_first)) begin
                if (v.u1 && v.rs1 == rd[w]) h = 1'b1;
                if (v.u2 && v.rs2 == rd[w]) h = 1'b1;
            end
        end
        return h;
    endfunction

    // Expected outputs for this cycle and the model state after the clock edge.
    function automatic logic [7:0] model_eval(input vec_t v, input bit wb_first, input int tmo,
                                              input mst_t cur, output mst_t nxt);
        logic [7:0] o;
        nxt = cur;
        nxt.just_ret = 1'b0;
        o = O_NONE;
        if (cur.age > 0) begin
            if (v.done || cur.age > tmo) begin
                nxt.age = 0;
                nxt.just_ret = 1'b1;
                if (!v.done) nxt.err = 1'b1;
            end else begin
                o = O_FREEZE;
                nxt.age = cur.age + 1;
            end
        end else if (v.br) begin
            o = O_BRANCH;
        end else if (v.exmdu && !cur.just_ret) begin
            o = O_START;
            nxt.age = 1;
        end else if (model_hz(v, wb_first)) begin
            o = O_RAW;
        end
        o[0] = cur.err;
        return o;
    endfunction

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_rd = v.exrd; ma_rd = v.mard; wb_rd = v.wbrd;
        ex_reg_en = v.exen; ma_reg_en = v.maen; wb_reg_en = v.wben;
        ex_mdu = v.exmdu; br_taken = v.br; mdu_done = v.done;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply('0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    rec_t tbl [10];

    initial begin
        vec_t v;
        mst_t m1, m0, n1, n0;
        logic [7:0] e1, e0;
        int cnt_a, cnt_b;

        tbl[0] = '{v: mkv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), e_wf1: O_NONE,   e_wf0: O_NONE};
        tbl[1] = '{v: mkv(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), e_wf1: O_RAW,    e_wf0: O_RAW};
        tbl[2] = '{v: mkv(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), e_wf1: O_NONE,   e_wf0: O_NONE};
        tbl[3] = '{v: mkv(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0), e_wf1: O_NONE,   e_wf0: O_NONE};
        tbl[4] = '{v: mkv(5'd1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), e_wf1: O_RAW,    e_wf0: O_RAW};
        tbl[5] = '{v: mkv(5'd1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0), e_wf1: O_NONE,   e_wf0: O_NONE};
        tbl[6] = '{v: mkv(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0), e_wf1: O_NONE,   e_wf0: O_RAW};
        tbl[7] = '{v: mkv(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), e_wf1: O_BRANCH, e_wf0: O_BRANCH};
        tbl[8] = '{v: mkv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), e_wf1: O_BRANCH, e_wf0: O_BRANCH};
        tbl[9] = '{v: mkv(5'd4, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0), e_wf1: O_RAW,    e_wf0: O_RAW};

        // reset state: outputs silent even with hazard and branch inputs active
        @(negedge clk);
        apply(tbl[7].v);
        #1;
        check("reset_dut", ov0, O_NONE);
        check("reset_wb0", ov1, O_NONE);
        check("reset_t4", ov2, O_NONE);
        do_reset();

        // RUN-state decision table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(tbl[i].v);
            #1;
            check($sformatf("table%0d_wf1", i), ov0, tbl[i].e_wf1);
            check($sformatf("table%0d_wf0", i), ov1, tbl[i].e_wf0);
        end

        // RAW stall as the x5 writer moves EX -> MA -> WB -> gone
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v = mkv(5'd5, 1'b1, 5'd0, 1'b0, (c == 0) ? 5'd5 : 5'd0, c == 0,
                    (c == 1) ? 5'd5 : 5'd0, c == 1, (c == 2) ? 5'd5 : 5'd0, c == 2, 1'b0);
            apply(v);
            #1;
            if (ov0[7]) cnt_a++;
            if (ov1[7]) cnt_b++;
            check($sformatf("raw_seq%0d_wf1", c), ov0, (c < 2) ? O_RAW : O_NONE);
            check($sformatf("raw_seq%0d_wf0", c), ov1, (c < 3) ? O_RAW : O_NONE);
        end
        check_int("raw_stall_cycles_wf1", cnt_a, 2);
        check_int("raw_stall_cycles_wf0", cnt_b, 3);

        // MDU handshake: done arrives 8 cycles after the start pulse was taken
        do_reset();
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            v = '0;
            v.exmdu = (c <= 10);
            v.done = (c == 9);
            apply(v);
            #1;
            if (ov0[7]) cnt_a++;
            if (ov0[1]) cnt_b++;
            check($sformatf("mdu_seq%0d", c), ov0, (c == 0) ? O_START : (c < 9) ? O_FREEZE : O_NONE);
        end
        check_int("mdu_stall_cycles", cnt_a, 9);
        check_int("mdu_start_pulses", cnt_b, 1);

        // MDU timeout on the 4-cycle instance, done never arrives
        do_reset();
        cnt_a = 0;
        @(negedge clk);
        v = '0; v.exmdu = 1'b1;
        apply(v);
        #1;
        check("tmo_start", ov2, O_START);
        if (ov2[7]) cnt_a++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            apply('0);
            #1;
            if (!ov2[7]) break;
            cnt_a++;
        end
        check_int("tmo_stall_cycles", cnt_a, 5);
        check("tmo_release_noerr_yet", ov2, O_NONE);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("tmo_err_sticky%0d", c), ov2, 8'h01);
        end
        do_reset();
        @(negedge clk);
        #1;
        check("tmo_err_cleared", ov2, O_NONE);

        // async reset in the middle of an MDU wait
        @(negedge clk);
        v = '0; v.exmdu = 1'b1;
        apply(v);
        #1;
        check("arst_start", ov0, O_START);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("arst_wait%0d", c), ov0, O_FREEZE);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_dut_zero", ov0, O_NONE);
        check("arst_t4_zero", ov2, O_NONE);
        @(negedge clk);
        rst = 1'b0;
        apply('0);
        #1;
        check("arst_idle_after", ov0, O_NONE);
        @(negedge clk);
        v = '0; v.exmdu = 1'b1;
        apply(v);
        #1;
        check("arst_run_relaunch", ov0, O_START);

        // randomized run against the behavioural model
        do_reset();
        m1 = '0;
        m0 = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.exrd  = 5'($urandom_range(0, 7));
            v.mard  = 5'($urandom_range(0, 7));
            v.wbrd  = 5'($urandom_range(0, 7));
            v.exen  = 1'($urandom_range(0, 1));
            v.maen  = 1'($urandom_range(0, 1));
            v.wben  = 1'($urandom_range(0, 1));
            v.exmdu = ($urandom_range(0, 7) == 0);
            v.br    = ($urandom_range(0, 9) == 0);
            v.done  = ($urandom_range(0, 5) == 0);
            apply(v);
            #1;
            e1 = model_eval(v, 1'b1, 64, m1, n1);
            e0 = model_eval(v, 1'b0, 64, m0, n0);
            check($sformatf("rand%0d_wf1", c), ov0, e1);
            check($sformatf("rand%0d_wf0", c), ov1, e0);
            m1 = n1;
            m0 = n0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central interlock and scheduling controller for the 5-stage RV32IM pipeline (IF, ID, EX, MA, WB). There is no forwarding.
- Detects RAW hazards between the ID instruction and older in-flight writers, and stalls the front end until the writer retires.
- Squashes wrong-path instructions on taken branches and jumps.
- Sequences the multi-cycle M-extension unit (MDU) with a start/done handshake, freezing the pipeline while it runs.
- Drives the PC, IF_ID, IF_EX and EX_MA stall, flush and bubble controls.

Parameters:
- MDU_TIMEOUT, 64: maximum MDU busy cycles before forced release; range 2..255.
- WB_WRITE_FIRST, 1: 1 = the register file writes on the edge ahead of the ID read, so the WB stage is not a hazard source; 0 = WB destination is also compared.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_RS1, ID_RS2  in  5 each  source register addresses in ID.
- ID_USE_RS1, ID_USE_RS2  in  1 each  ID instruction actually reads that source.
- EX_RD, MA_RD, WB_RD  in  5 each  destination register per stage.
- EX_REG_EN, MA_REG_EN, WB_REG_EN  in  1 each  register write enable per stage.
- EX_MDU  in  1  EX holds MUL/DIV/REM.
- BR_TAKEN  in  1  branch/jump resolved taken in EX.
- MDU_DONE  in  1  MDU result valid, single-cycle pulse.
- PC_STALL  out  1  hold PC.
- IFID_STALL  out  1  hold IF_ID register.
- IFID_FLUSH  out  1  load NOP into IF_ID.
- IDEX_STALL  out  1  hold IF_EX register.
- IDEX_BUBBLE  out  1  load NOP into IF_EX.
- EXMA_BUBBLE  out  1  load NOP into EX_MA.
- MDU_START  out  1  one-cycle start pulse to MDU.
- MDU_ERR  out  1  sticky timeout flag.

Behaviour:
- FSM states: RUN, MDU_LAUNCH, MDU_WAIT.
- Reset: state=RUN, timeout counter=0, MDU_ERR=0. All outputs are 0 while RESET is high.
- RESET asserted mid-operation aborts any MDU wait immediately, with no START or DONE side effects.
- Hazard term: hz = (ID_USE_RS1 and ID_RS1 != 0 and ID_RS1 matches a writer) or the same test on RS2.
  - Writers are EX, MA, and WB when WB_WRITE_FIRST=0.
  - A writer qualifies only if REG_EN=1 and RD != 0.
  - Register x0 never causes a hazard.
- RUN state outputs, combinational, same cycle:
  - BR_TAKEN=1: IFID_FLUSH=1, IDEX_BUBBLE=1, no stalls. The PC loads the branch target. BR_TAKEN overrides hz.
  - Else EX_MDU=1: MDU_START=1, all four stalls asserted (PC, IFID, IDEX hold; EXMA_BUBBLE=1); next state MDU_LAUNCH.
  - Else hz=1: PC_STALL=1, IFID_STALL=1, IDEX_BUBBLE=1. The stall repeats every cycle while hz holds, giving at most 2 bubbles (3 when WB_WRITE_FIRST=0).
  - Else: all outputs 0.
- MDU_LAUNCH: lasts exactly one cycle.
  - PC_STALL, IFID_STALL, IDEX_STALL and EXMA_BUBBLE held at 1; MDU_START=0.
  - Counter cleared to 1. Next state MDU_WAIT; if MDU_DONE=1 in this cycle, go directly to RUN with stalls released.
- MDU_WAIT:
  - Same stalls as MDU_LAUNCH; the counter increments each cycle and saturates.
  - MDU_DONE=1: stalls drop in the same cycle, the MDU result enters EX_MA, next state RUN.
  - Counter reaches MDU_TIMEOUT without DONE: set MDU_ERR (sticky until reset), release the stall, return to RUN.
- Re-launch rule: in RUN, EX_MDU is ignored for exactly one cycle after returning from an MDU state, so the released instruction is not relaunched.
- No combinational path from any output back to hz; the block has no internal loops.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs PERF_STALL (32 bits; cycles with PC_STALL=1), PERF_FLUSH (32 bits; count of BR_TAKEN flushes) and PERF_MDU (32 bits; cycles spent in MDU states).
  - Counters wrap modulo 2^32 and clear on RESET.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state enum {RUN, MDU_LAUNCH, MDU_WAIT}.
  - REG_ZERO = 5'd0.
  - Default MDU_TIMEOUT value.
- One sub-module, hazard_cmp: purely combinational RAW comparator, taking (rs, use, rd, reg_en) and returning a match.
  - Instantiated once per source/writer pair (4, or 6 when WB_WRITE_FIRST=0).

Test Plan:
- RAW stall: EX writes x5 (REG_EN=1) and ID reads RS1=x5 → PC_STALL=IFID_STALL=IDEX_BUBBLE=1 for 2 cycles, then 0 once the writer reaches WB (WB_WRITE_FIRST=1).
- x0 immunity: EX_RD=0 with REG_EN=1 and ID_RS1=0 → no stall on any cycle.
- Branch priority: BR_TAKEN=1 and hz=1 in the same cycle → IFID_FLUSH=IDEX_BUBBLE=1, PC_STALL=0.
- MDU handshake: EX_MDU=1, MDU_DONE pulsed 8 cycles after MDU_START → MDU_START high for exactly one cycle; stalls held for 9 cycles total; no relaunch afterwards.
- MDU timeout: MDU_TIMEOUT=4, DONE never arrives → stall released after 4 counted cycles; MDU_ERR=1 and stays set until RESET.
- Async reset: RESET asserted during MDU_WAIT, between clock edges → all outputs 0 immediately; state is RUN after RESET is released.
